// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and constants for the iterative RV32M unit
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;
  localparam int MDU_ITER = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN = 32'h80000000;
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step, shifting one dividend bit into the remainder
module mdu_divstep #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] sh, diff;
  always_comb begin
    sh = {rem_i, quo_i[W-1]};
    diff = sh - {1'b0, div_i};
    rem_o = diff[W] ? sh[W-1:0] : diff[W-1:0];
    quo_o = {quo_i[W-2:0], ~diff[W]};
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one result bit per cycle, with write-back port
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] write_data
);
  mdu_state_e state_q, state_d;
  mdu_op_e op_q;
  logic [4:0] rd_q, wb_addr_q;
  logic [XLEN-1:0] a_q, b_q, hi_q, lo_q, res_q, wd_q;
  logic [CNT_W-1:0] cnt_q;
  logic neg_q, done_q, wb_en_q;
  logic sa, sb, a_neg, b_neg, is_div, spec_dz, spec_ov;
  logic [XLEN:0] msum;
  logic [XLEN-1:0] rem_n, quo_n, fix_res;
  logic [2*XLEN-1:0] prod, prod_f;

  mdu_divstep #(.W(XLEN)) u_divstep (
    .rem_i(hi_q),
    .quo_i(lo_q),
    .div_i(b_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );

  always_comb begin
    is_div  = op_is_div(op_q);
    sa      = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sb      = op_q inside {OP_MULH, OP_DIV, OP_REM};
    a_neg   = sa & a_q[XLEN-1];
    b_neg   = sb & b_q[XLEN-1];
    spec_dz = is_div && (b_q == '0);
    spec_ov = (op_q == OP_DIV || op_q == OP_REM) && (a_q == INT_MIN) && (b_q == '1);
    msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    prod    = {hi_q, lo_q};
    prod_f  = neg_q ? -prod : prod;
    // divide keeps the remainder in hi_q and the quotient in lo_q
    fix_res = is_div ? (op_q[1] ? (neg_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q))
                     : (op_q == OP_MUL ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN]);
  end

  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (start && !kill) ? S_PREP : S_IDLE;
      S_PREP:  state_d = (spec_dz || spec_ov) ? S_DONE : S_CALC;
      S_CALC:  state_d = (cnt_q == CNT_W'(MDU_ITER - 1)) ? S_FIX : S_CALC;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_MUL;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wd_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start && !kill) begin
          op_q <= mdu_op_e'(funct3);
          rd_q <= rd_addr;
          a_q  <= rs1_data;
          b_q  <= rs2_data;
        end
        S_PREP: begin
          hi_q  <= '0;
          lo_q  <= a_neg ? -a_q : a_q;
          b_q   <= b_neg ? -b_q : b_q;
          neg_q <= a_neg ^ (b_neg & ~(is_div & op_q[1]));
          cnt_q <= '0;
          res_q <= spec_dz ? (op_q[1] ? a_q : DIV_ZERO_Q) : (op_q[1] ? '0 : INT_MIN);
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          {hi_q, lo_q} <= is_div ? {rem_n, quo_n} : {msum, lo_q[XLEN-1:1]};
        end
        S_FIX: res_q <= fix_res;
        S_DONE: if (!kill) begin
          done_q    <= 1'b1;
          wb_en_q   <= (rd_q != '0);
          wb_addr_q <= rd_q;
          wd_q      <= res_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done       = done_q;
    wb_en      = wb_en_q;
    wb_addr    = wb_addr_q;
    write_data = wd_q;
  end
endmodule
